// File: rtl/boot_pkg.sv
// boot_pkg: shared types and constants for the TinyRV1 boot sequencer.
`default_nettype none

package boot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic        MEMREQ_READ       = 1'b0;
    localparam logic        MEMREQ_WRITE      = 1'b1;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_0200;

endpackage

`default_nettype wire

// File: rtl/proc_boot_ctrl_if.sv
// proc_boot_ctrl_if: host load stream plus processor-side and memory-side dmem request buses.
`default_nettype none

interface proc_boot_ctrl_if;

    logic        load_val;
    logic        load_rdy;
    logic [31:0] load_data;

    logic        proc_dmemreq_val;
    logic        proc_dmemreq_type;
    logic [31:0] proc_dmemreq_addr;
    logic [31:0] proc_dmemreq_wdata;

    logic        dmemreq_val;
    logic        dmemreq_type;
    logic [31:0] dmemreq_addr;
    logic [31:0] dmemreq_wdata;

    modport slave (
        input  load_val, load_data,
        input  proc_dmemreq_val, proc_dmemreq_type, proc_dmemreq_addr, proc_dmemreq_wdata,
        output load_rdy,
        output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata
    );

    modport master (
        output load_val, load_data,
        output proc_dmemreq_val, proc_dmemreq_type, proc_dmemreq_addr, proc_dmemreq_wdata,
        input  load_rdy,
        input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata
    );

endinterface

`default_nettype wire

// File: rtl/proc_boot_mux.sv
// proc_boot_mux: selects whether the loader or the processor owns the memory data port.
`default_nettype none

module proc_boot_mux (
    input  logic        sel_proc,
    input  logic        ld_val,
    input  logic        ld_type,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    input  logic        proc_val,
    input  logic        proc_type,
    input  logic [31:0] proc_addr,
    input  logic [31:0] proc_wdata,
    output logic        mem_val,
    output logic        mem_type,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata
);

    always_comb begin
        mem_val   = ld_val;
        mem_type  = ld_type;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
        if (sel_proc) begin
            mem_val   = proc_val;
            mem_type  = proc_type;
            mem_addr  = proc_addr;
            mem_wdata = proc_wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/proc_boot_ctrl.sv
// proc_boot_ctrl: streams a length-prefixed program into memory with the processor held in reset,
// then runs the processor until it reports a halt code or exhausts its cycle budget.
`default_nettype none

module proc_boot_ctrl
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          MAX_WORDS  = 256,
    parameter logic [31:0] MAX_CYCLES = 32'd1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    proc_boot_ctrl_if.slave       bus,
    output logic                  proc_rst,
    input  logic [31:0]           proc_out2,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic                  err,
    output logic [31:0]           halt_code,
    output logic [31:0]           cycle_cnt
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   r_remaining;
    logic               r_load_rdy;
    logic               w_xfer;
    logic               w_halt;
    logic               w_expire;
    logic               w_len_bad;
    logic               w_ld_val;
    logic               w_ld_type;
    logic [31:0]        w_ld_addr;
    logic [31:0]        w_ld_wdata;

    assign bus.load_rdy = r_load_rdy;
    assign w_xfer       = bus.load_val & r_load_rdy;
    assign w_halt       = (proc_out2 != 32'd0);
    assign w_expire     = (cycle_cnt == (MAX_CYCLES - 32'd1));
    assign w_len_bad    = (bus.load_data > 32'(MAX_WORDS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Write strobes are combinational so the memory commits each word on its own transfer edge.
    always_comb begin
        w_next     = r_state;
        w_ld_val   = 1'b0;
        w_ld_type  = MEMREQ_READ;
        w_ld_addr  = 32'd0;
        w_ld_wdata = 32'd0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_xfer) begin
                    if (bus.load_data == 32'd0) begin
                        w_next = ST_RUN;
                    end else if (!w_len_bad) begin
                        w_next = ST_LOAD;
                    end else begin
                        w_next = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (w_xfer) begin
                    w_ld_val   = 1'b1;
                    w_ld_type  = MEMREQ_WRITE;
                    w_ld_addr  = BASE_ADDR + (32'(r_idx) << 2);
                    w_ld_wdata = bus.load_data;
                    if (r_remaining == IDX_W'(1)) begin
                        w_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_halt || w_expire) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proc_rst    <= 1'b1;
            r_load_rdy  <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            err         <= 1'b0;
            halt_code   <= 32'd0;
            cycle_cnt   <= 32'd0;
            r_idx       <= '0;
            r_remaining <= '0;
        end else begin
            proc_rst   <= (w_next != ST_RUN);
            r_load_rdy <= (w_next != ST_RUN);
            busy       <= (w_next == ST_LOAD) || (w_next == ST_RUN);
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_xfer) begin
                        done        <= w_len_bad;
                        err         <= w_len_bad;
                        timeout     <= 1'b0;
                        halt_code   <= 32'd0;
                        cycle_cnt   <= 32'd0;
                        r_idx       <= '0;
                        r_remaining <= bus.load_data[IDX_W-1:0];
                    end
                end
                ST_LOAD: begin
                    if (w_xfer) begin
                        r_idx       <= r_idx + 1'b1;
                        r_remaining <= r_remaining - 1'b1;
                    end
                end
                ST_RUN: begin
                    cycle_cnt <= cycle_cnt + 32'd1;
                    // A halt seen on the budget's final cycle still counts as a halt.
                    if (w_halt) begin
                        halt_code <= proc_out2;
                        done      <= 1'b1;
                    end else if (w_expire) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    proc_boot_mux u_mux (
        .sel_proc   (r_state == ST_RUN),
        .ld_val     (w_ld_val),
        .ld_type    (w_ld_type),
        .ld_addr    (w_ld_addr),
        .ld_wdata   (w_ld_wdata),
        .proc_val   (bus.proc_dmemreq_val),
        .proc_type  (bus.proc_dmemreq_type),
        .proc_addr  (bus.proc_dmemreq_addr),
        .proc_wdata (bus.proc_dmemreq_wdata),
        .mem_val    (bus.dmemreq_val),
        .mem_type   (bus.dmemreq_type),
        .mem_addr   (bus.dmemreq_addr),
        .mem_wdata  (bus.dmemreq_wdata)
    );

endmodule

`default_nettype wire

// File: doc/proc_boot_ctrl.md
Name: proc_boot_ctrl

Overview:
Sequencer that sits between a host word stream, the memory and the TinyRV1 processor.
- Holds the processor in reset while a program streams in; each word is written into memory through the memory's read/write (data) port.
- Then releases the processor and monitors it until it halts or times out.
- When not running, the controller owns the memory data port. In RUN it passes the processor's dmem traffic straight through.

Parameters:
- BASE_ADDR, 32'h0000_0200, byte address of the first loaded word (the processor reset vector).
- MAX_WORDS, 256, largest accepted program length in words.
- MAX_CYCLES, 32'd1_000_000, RUN cycle budget before timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- load_val  in  1  host word valid
- load_rdy  out  1  controller ready for a host word
- load_data  in  32  host word: first word is the length N, then N program words
- proc_rst  out  1  active-high reset to the processor
- proc_dmemreq_val  in  1  processor dmem request valid
- proc_dmemreq_type  in  1  processor dmem request type
- proc_dmemreq_addr  in  32  processor dmem request address
- proc_dmemreq_wdata  in  32  processor dmem write data
- proc_out2  in  32  processor out2; a nonzero value signals halt
- dmemreq_val  out  1  memory data-port request valid
- dmemreq_type  out  1  memory data-port type (1 = write)
- dmemreq_addr  out  32  memory data-port address
- dmemreq_wdata  out  32  memory data-port write data
- busy  out  1  load or run in progress
- done  out  1  run finished
- timeout  out  1  run ended by cycle budget
- err  out  1  length word was rejected
- halt_code  out  32  captured proc_out2 at halt
- cycle_cnt  out  32  RUN cycles elapsed

Behaviour:
- States: IDLE, LOAD, RUN, DONE. The state register and all registered outputs reset asynchronously when rst=0.
- Reset values:
  - state=IDLE, proc_rst=1, load_rdy=1.
  - dmemreq_val=0, dmemreq_type=0, dmemreq_addr=0, dmemreq_wdata=0.
  - busy=0, done=0, timeout=0, err=0, halt_code=0, cycle_cnt=0.
  - Internal word index idx=0.
- Handshake: a word transfers on a rising edge with load_val & load_rdy. load_rdy=1 in IDLE, LOAD and DONE, and 0 in RUN. load_rdy never depends on load_val.
- IDLE or DONE, on a transfer, load_data is the length N. done, timeout, err, halt_code and cycle_cnt are cleared.
  - N == 0: go to RUN.
  - 1 <= N <= MAX_WORDS: go to LOAD, idx=0, remaining=N.
  - N > MAX_WORDS: go to DONE with err=1, done=1; no memory writes.
- LOAD, on a transfer, in the same cycle (combinational):
  - dmemreq_val=1, type=1, addr=BASE_ADDR+4*idx, wdata=load_data; the memory commits the write at that edge.
  - idx increments. The Nth transfer moves the state to RUN.
  - Cycles without a transfer drive dmemreq_val=0.
  - busy=1.
- Memory port mux: in RUN, dmemreq_* = proc_dmemreq_*. In all other states the loader drives it, and val=0 unless a LOAD transfer occurs.
- proc_rst is registered. It is 0 exactly while the state is RUN, so it falls in the first RUN cycle and rises in the first DONE cycle.
- RUN:
  - busy=1; cycle_cnt increments every cycle, 32-bit, starting from 0.
  - proc_out2 != 0: go to DONE, halt_code=proc_out2, done=1.
  - Otherwise cycle_cnt == MAX_CYCLES-1: go to DONE, timeout=1, done=1.
  - If both occur in the same cycle, halt wins and timeout stays 0.
- DONE: busy=0; status holds until a new length word is accepted.
- Reset mid-LOAD or mid-RUN returns to IDLE with proc_rst=1. Words already written stay in memory.

Decomposition:
- boot_pkg: state enum (IDLE, LOAD, RUN, DONE), MEMREQ_READ=0 and MEMREQ_WRITE=1, default BASE_ADDR.
- Sub-module proc_boot_mux: purely combinational dmemreq_* selection between loader and processor. The FSM, counters and status registers stay in proc_boot_ctrl.

Test Plan:
- Hold rst=0 for 3 cycles with load_val=1 -> all outputs at reset values, no memory write, proc_rst=1.
- Stream N=3 then 0x11111111, 0x22222222, 0x33333333 back-to-back -> three writes to 0x200, 0x204, 0x208 in consecutive cycles; proc_rst=0 the cycle after the third write; busy=1 throughout.
- Same load with load_val gaps of 2 cycles -> identical write addresses and data; dmemreq_val=0 in gap cycles.
- In RUN, drive proc_out2=0x5 after 10 cycles -> DONE, halt_code=0x5, cycle_cnt=10, proc_rst=1, timeout=0.
- MAX_CYCLES=16, proc_out2 held 0 -> timeout=1 and done=1 after 16 RUN cycles. Repeat with proc_out2 nonzero on cycle 15 -> timeout=0.
- N=MAX_WORDS+1 -> err=1, done=1, no writes. Then N=0 -> RUN immediately with err cleared. Then assert rst=0 mid-LOAD at word 2 of 3 -> IDLE and proc_rst=1 immediately.
